// File: rtl/lut_port_arbiter.sv
// lut_port_arbiter: shares one lookup-table port between N_REQ requesters,
// launches configuration writes on the table databus with priority over
// lookups, and routes each fixed-latency result back to its requester via
// a tag pipeline.
module lut_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LUT_LAT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_data,
    input  logic                    cfg_valid,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [DATA_W-1:0]       cfg_wdata,
    output logic                    cfg_ready,
    output logic [ADDR_W-1:0]       lut_in,
    input  logic [DATA_W-1:0]       lut_out,
    output logic                    lut_bus_valid,
    output logic [DATA_W/8-1:0]     lut_bus_wstrb,
    output logic [ADDR_W-1:0]       lut_bus_addr,
    output logic [DATA_W-1:0]       lut_bus_wdata,
    output logic                    busy
);

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STAGES = LUT_LAT + 1;
    localparam int LAST   = STAGES - 1;
    localparam int STRB_W = DATA_W / 8;

    logic [IDX_W-1:0] rr_ptr;
    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;

    // Tag pipeline: stage 0 is loaded with the grant, the last stage lines
    // up with the table output.
    logic             vld_p [STAGES];
    logic [IDX_W-1:0] idx_p [STAGES];

    // Round-robin search from rr_ptr; a pending cfg write or disabled
    // arbiter suppresses every grant.
    always_comb begin
        logic [IDX_W-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!rst && enable && !cfg_valid) begin
            for (int i = 0; i < N_REQ; i++) begin
                cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    // One-hot ready for the winner; writes are always accepted outside reset.
    always_comb begin
        req_ready = '0;
        if (grant_any)
            req_ready[grant_idx] = 1'b1;
        cfg_ready = cfg_valid & ~rst;
    end

    // Pointer moves just past the winner so it becomes lowest priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (grant_any)
            rr_ptr <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Lookup address register: loads the winner's address, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lut_in <= '0;
        else if (grant_any)
            lut_in <= req_addr[grant_idx*ADDR_W +: ADDR_W];
    end

    // Databus register: a write occupies exactly the cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lut_bus_valid <= 1'b0;
            lut_bus_wstrb <= '0;
            lut_bus_addr  <= '0;
            lut_bus_wdata <= '0;
        end else begin
            lut_bus_valid <= cfg_valid;
            lut_bus_wstrb <= cfg_valid ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
            if (cfg_valid) begin
                lut_bus_addr  <= cfg_addr;
                lut_bus_wdata <= cfg_wdata;
            end
        end
    end

    // Tag valid bits: reset drops every in-flight lookup.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++)
                vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= grant_any;
            for (int k = 1; k < STAGES; k++)
                vld_p[k] <= vld_p[k-1];
        end
    end

    // Tag indices only matter while their valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        idx_p[0] <= grant_idx;
        for (int k = 1; k < STAGES; k++)
            idx_p[k] <= idx_p[k-1];
    end

    // Route the table result to the requester recorded in the last stage.
    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (vld_p[LAST]) begin
            resp_valid[idx_p[LAST]] = 1'b1;
            resp_data               = lut_out;
        end
    end

    // Busy while any tag stage holds a live lookup.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < STAGES; k++)
            busy = busy | vld_p[k];
    end

endmodule

// File: tb/tb_lut_port_arbiter.sv
// Testbench for lut_port_arbiter: a behavioural table with fixed latency,
// a directed driver that pushes expected responses, and a monitor that
// pops and compares whenever a response appears.
module tb_lut_port_arbiter;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int LUT_LAT = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_data;
    logic                    cfg_valid;
    logic [ADDR_W-1:0]       cfg_addr;
    logic [DATA_W-1:0]       cfg_wdata;
    logic                    cfg_ready;
    logic [ADDR_W-1:0]       lut_in;
    logic [DATA_W-1:0]       lut_out;
    logic                    lut_bus_valid;
    logic [DATA_W/8-1:0]     lut_bus_wstrb;
    logic [ADDR_W-1:0]       lut_bus_addr;
    logic [DATA_W-1:0]       lut_bus_wdata;
    logic                    busy;

    logic [ADDR_W-1:0] req_addr_arr [N_REQ];
    assign req_addr = {req_addr_arr[3], req_addr_arr[2], req_addr_arr[1], req_addr_arr[0]};

    lut_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LUT_LAT(LUT_LAT)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
        .lut_in(lut_in), .lut_out(lut_out),
        .lut_bus_valid(lut_bus_valid), .lut_bus_wstrb(lut_bus_wstrb),
        .lut_bus_addr(lut_bus_addr), .lut_bus_wdata(lut_bus_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural table: unwritten words read back as their own address.
    bit   [255:0]      wr_flag = '0;
    logic [DATA_W-1:0] tbl  [256];
    logic [DATA_W-1:0] pipe [LUT_LAT];
    assign lut_out = pipe[LUT_LAT-1];

    always @(posedge clk) begin
        if (lut_bus_valid && lut_bus_wstrb == 4'hF) begin
            tbl[lut_bus_addr]     <= lut_bus_wdata;
            wr_flag[lut_bus_addr] <= 1'b1;
        end
        pipe[0] <= wr_flag[lut_in] ? tbl[lut_in] : {24'h0, lut_in};
        for (int k = 1; k < LUT_LAT; k++)
            pipe[k] <= pipe[k-1];
    end

    // Scoreboard
    typedef struct {
        int               due;
        logic [N_REQ-1:0] oh;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid != '0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: actual=%b required=none (cycle %0d)", resp_valid, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("resp_valid", 64'(resp_valid), 64'(mon_e.oh));
                chk("resp_data", 64'(resp_data), 64'(mon_e.data));
                chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_resp: actual=none required=%b (cycle %0d)", q[0].oh, cyc);
            void'(q.pop_front());
        end
    end

    // Driver-side reference state
    logic [DATA_W-1:0] ref_mem [256];
    logic [ADDR_W-1:0] exp_lut_in;
    logic              exp_bus_v;
    logic [ADDR_W-1:0] exp_bus_a;
    logic [DATA_W-1:0] exp_bus_d;

    // One cycle of stimulus applied at the negedge; ready checked combinationally.
    task automatic step(input logic cv, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                        input logic en, input logic [N_REQ-1:0] rv, input logic [N_REQ-1:0] exp_rdy);
        exp_t e;
        cfg_valid = cv; cfg_addr = ca; cfg_wdata = cd; enable = en; req_valid = rv;
        #1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("cfg_ready", 64'(cfg_ready), 64'(cv));
        chk("lut_bus_valid", 64'(lut_bus_valid), 64'(exp_bus_v));
        chk("lut_bus_wstrb", 64'(lut_bus_wstrb), exp_bus_v ? 64'hF : 64'h0);
        if (exp_bus_v) begin
            chk("lut_bus_addr", 64'(lut_bus_addr), 64'(exp_bus_a));
            chk("lut_bus_wdata", 64'(lut_bus_wdata), 64'(exp_bus_d));
        end
        chk("lut_in", 64'(lut_in), 64'(exp_lut_in));
        exp_bus_v = cv; exp_bus_a = ca; exp_bus_d = cd;
        if (cv) ref_mem[ca] = cd;
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_rdy[i]) begin
                exp_lut_in = req_addr_arr[i];
                e.due  = cyc + 1 + LUT_LAT;
                e.oh   = exp_rdy;
                e.data = ref_mem[req_addr_arr[i]];
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'h00, 32'h0, en, 4'b0000, 4'b0000);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
        chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'h0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
        chk({tag, "_resp_data"}, 64'(resp_data), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_lut_in"}, 64'(lut_in), 64'h0);
        chk({tag, "_lut_bus_valid"}, 64'(lut_bus_valid), 64'h0);
        chk({tag, "_lut_bus_wstrb"}, 64'(lut_bus_wstrb), 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
        for (int i = 0; i < N_REQ; i++) req_addr_arr[i] = 8'h00;
        exp_lut_in = '0; exp_bus_v = 1'b0; exp_bus_a = '0; exp_bus_d = '0;

        // Reset with every request input asserted
        rst = 1'b1; enable = 1'b1; req_valid = 4'b1111;
        cfg_valid = 1'b1; cfg_addr = 8'h00; cfg_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;

        // Write then read back the new word (rr_ptr 0 -> 3)
        req_addr_arr[2] = 8'h10;
        step(1'b1, 8'h10, 32'hCAFEBABE, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 8'h00, 32'h0,        1'b1, 4'b0100, 4'b0100);
        idle(1, 1'b1);

        // Wrap and sparse: rr_ptr 3 -> grant 3, then 0
        req_addr_arr[3] = 8'hFF; req_addr_arr[0] = 8'h05;
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1001, 4'b1000);
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b0001, 4'b0001);
        idle(5, 1'b1);
        chk("busy_idle", 64'(busy), 64'h0);

        // Write priority: 3-write burst stalls requesters 1 and 3 (rr_ptr 1)
        req_addr_arr[1] = 8'h21; req_addr_arr[3] = 8'h30;
        step(1'b1, 8'h20, 32'hD00D0020, 1'b1, 4'b1010, 4'b0000);
        step(1'b1, 8'h21, 32'hD00D0021, 1'b1, 4'b1010, 4'b0000);
        step(1'b1, 8'h22, 32'hD00D0022, 1'b1, 4'b1010, 4'b0000);
        step(1'b0, 8'h00, 32'h0,        1'b1, 4'b1010, 4'b0010);
        step(1'b0, 8'h00, 32'h0,        1'b1, 4'b1000, 4'b1000);
        idle(1, 1'b1);

        // Enable drop with 3 lookups in flight; a write still goes through
        req_addr_arr[0] = 8'h01; req_addr_arr[1] = 8'h02;
        req_addr_arr[2] = 8'h03; req_addr_arr[3] = 8'h04;
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1111, 4'b0001);
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1111, 4'b0010);
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1111, 4'b0100);
        step(1'b0, 8'h00, 32'h0, 1'b0, 4'b1111, 4'b0000);
        chk("busy_inflight", 64'(busy), 64'h1);
        step(1'b1, 8'h40, 32'hBEEF0040, 1'b0, 4'b1111, 4'b0000);
        for (int i = 0; i < 4; i++)
            step(1'b0, 8'h00, 32'h0, 1'b0, 4'b1111, 4'b0000);
        chk("busy_drained", 64'(busy), 64'h0);

        // Mid-operation reset with 2 lookups in flight (rr_ptr 3)
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1111, 4'b1000);
        step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1111, 4'b0001);
        #2;
        cfg_valid = 1'b1;
        rst = 1'b1;
        q.delete();
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0; cfg_valid = 1'b0;
        exp_lut_in = '0; exp_bus_v = 1'b0;
        idle(6, 1'b1);

        // Round-robin from reset: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++)
            step(1'b0, 8'h00, 32'h0, 1'b1, 4'b1111, 4'(1 << (i % 4)));
        idle(8, 1'b1);
        chk("drain_queue", 64'(q.size()), 64'h0);
        chk("busy_end", 64'(busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
